// File: rtl/demux_stream_1_n_if.sv
// Handshake bundle for demux_stream_1_n: one producer-side stream, N_OUT consumer-side
// streams, plus round-robin pointer and drop status.
//   slave  : the demux itself (takes the input stream, drives the output streams)
//   master : the surrounding datapath (producer + consumers)
interface demux_stream_1_n_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_OUT = 16
);
  localparam int unsigned SEL_W = $clog2(N_OUT);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       sel;
  logic                   mode;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [SEL_W-1:0]       rr_ptr;
  logic                   err;
  logic [7:0]             drop_cnt;

  modport slave (
    input  in_valid, in_data, sel, mode, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, err, drop_cnt
  );

  modport master (
    output in_valid, in_data, sel, mode, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, err, drop_cnt
  );
endinterface

// File: rtl/demux_stream_1_n.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per channel.
// Destination is sel (mode 0) or an auto-incrementing round-robin pointer (mode 1).
// Words addressed past N_OUT-1 are accepted and discarded, pulsing err and counting
// into a saturating drop_cnt.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux_stream_1_n_if.slave (in_* stream, sel/mode, out_* streams,
//                rr_ptr, err, drop_cnt)
module demux_stream_1_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_OUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_stream_1_n_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(N_OUT);

  logic [N_OUT-1:0]            valid_q, valid_d;
  logic [N_OUT-1:0][WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic                        err_q, err_d;
  logic [7:0]                  drop_q, drop_d;

  logic [SEL_W-1:0] dest;
  logic [N_OUT-1:0] tgt;
  logic             in_range;
  logic             in_ready;
  logic             xfer;

  // One-hot destination decode; an out-of-range destination yields no bit set, which
  // avoids ever indexing past N_OUT-1.
  always_comb begin
    dest = bus.mode ? rr_ptr_q : bus.sel;
    tgt  = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (dest == SEL_W'(i)) tgt[i] = 1'b1;
    end
  end

  assign in_range = |tgt;
  assign in_ready = !in_range || (|(tgt & (~valid_q | bus.out_ready)));
  assign xfer     = bus.in_valid && in_ready;

  always_comb begin
    valid_d = valid_q & ~bus.out_ready;
    data_d  = data_q;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      // A load wins over a same-cycle drain, keeping one word per cycle per channel.
      if (xfer && tgt[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = bus.in_data;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && bus.mode) begin
      rr_ptr_d = (rr_ptr_q == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
    err_d  = xfer && !in_range;
    drop_d = (err_d && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.rr_ptr    = rr_ptr_q;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_demux_stream_1_n.sv
// Bench for demux_stream_1_n: a 16-way instance (A) and a 10-way instance (B, which can
// see out-of-range selects). Directed table + sequences, then randomized traffic
// compared against a behavioural model.
module tb_demux_stream_1_n;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux_stream_1_n_if #(.WIDTH(16), .N_OUT(16)) ifa ();
  demux_stream_1_n_if #(.WIDTH(16), .N_OUT(10)) ifb ();

  demux_stream_1_n #(.WIDTH(16), .N_OUT(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  demux_stream_1_n #(.WIDTH(16), .N_OUT(10)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] cha(input int i);
    return ifa.out_data[i*16 +: 16];
  endfunction

  function automatic logic [15:0] chb(input int i);
    return ifb.out_data[i*16 +: 16];
  endfunction

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] din;
    logic        exp_ready;
    logic [15:0] exp_valid;
  } vec_t;

  vec_t vecs[16];

  // Behavioural model state, index 0 = A (16 channels), 1 = B (10 channels).
  bit          mv[2][16];
  logic [15:0] md[2][16];
  int          mp[2];
  int          mdrop[2];
  bit          merr[2];

  initial begin
    logic        sv[2];
    logic        sm[2];
    logic [3:0]  ss[2];
    logic [15:0] sd[2];
    logic [15:0] sr[2];

    for (int k = 0; k < 16; k++) begin
      vecs[k].sel       = 4'(k);
      vecs[k].din       = 16'hA500 + 16'(k);
      vecs[k].exp_ready = 1'b1;
      vecs[k].exp_valid = 16'(1) << k;
    end

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifa.in_valid = 1'b0; ifa.mode = 1'b0; ifa.sel = '0; ifa.in_data = '0; ifa.out_ready = '1;
    ifb.in_valid = 1'b0; ifb.mode = 1'b0; ifb.sel = '0; ifb.in_data = '0; ifb.out_ready = '1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", 32'(ifa.out_valid), 32'h0);
    chk("rst_a_data_zero", 32'(ifa.out_data == '0), 32'h1);
    chk("rst_a_rr", 32'(ifa.rr_ptr), 32'h0);
    chk("rst_a_err", 32'(ifa.err), 32'h0);
    chk("rst_a_drop", 32'(ifa.drop_cnt), 32'h0);
    chk("rst_b_valid", 32'(ifb.out_valid), 32'h0);
    chk("rst_b_drop", 32'(ifb.drop_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Addressed sweep
    for (int k = 0; k < 16; k++) begin
      ifa.sel      = vecs[k].sel;
      ifa.in_data  = vecs[k].din;
      ifa.in_valid = 1'b1;
      #1;
      chk("sweep_in_ready", 32'(ifa.in_ready), 32'(vecs[k].exp_ready));
      tick();
      chk("sweep_valid", 32'(ifa.out_valid), 32'(vecs[k].exp_valid));
      chk("sweep_data", 32'(cha(int'(vecs[k].sel))), 32'(vecs[k].din));
    end
    ifa.in_valid = 1'b0;
    tick();
    chk("sweep_drained", 32'(ifa.out_valid), 32'h0);

    // Backpressure on channel 3
    ifa.out_ready = 16'hFFF7;
    ifa.sel = 4'd3; ifa.in_data = 16'h1234; ifa.in_valid = 1'b1;
    #1;
    chk("bp_ready_first", 32'(ifa.in_ready), 32'h1);
    tick();
    chk("bp_held_valid", 32'(ifa.out_valid), 32'h0008);
    chk("bp_held_data", 32'(cha(3)), 32'h1234);
    ifa.in_data = 16'h5678;
    #1;
    chk("bp_ready_blocked", 32'(ifa.in_ready), 32'h0);
    tick();
    chk("bp_stable_data", 32'(cha(3)), 32'h1234);
    chk("bp_stable_valid", 32'(ifa.out_valid), 32'h0008);
    ifa.out_ready = '1;
    #1;
    chk("bp_ready_release", 32'(ifa.in_ready), 32'h1);
    tick();
    chk("bp_replaced_data", 32'(cha(3)), 32'h5678);
    chk("bp_replaced_valid", 32'(ifa.out_valid), 32'h0008);
    ifa.in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(ifa.out_valid), 32'h0);

    // Round-robin, 20 words
    ifa.mode = 1'b1; ifa.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ifa.in_data = 16'hC000 + 16'(k);
      tick();
      chk("rr_valid", 32'(ifa.out_valid), 32'(16'(1) << (k % 16)));
      chk("rr_data", 32'(cha(k % 16)), 32'(16'hC000 + 16'(k)));
      chk("rr_ptr", 32'(ifa.rr_ptr), 32'((k + 1) % 16));
    end
    ifa.in_valid = 1'b0;
    tick();
    chk("rr_ptr_end", 32'(ifa.rr_ptr), 32'd4);

    // Round-robin stall: fill channel 5 while it is not ready, then aim RR at it
    ifa.out_ready = 16'hFFDF;
    ifa.mode = 1'b0; ifa.sel = 4'd5; ifa.in_data = 16'h0555; ifa.in_valid = 1'b1;
    tick();
    chk("rr_hold_ptr_mode0", 32'(ifa.rr_ptr), 32'd4);
    ifa.mode = 1'b1; ifa.in_data = 16'h0444;
    tick();
    chk("rr_stall_ptr5", 32'(ifa.rr_ptr), 32'd5);
    ifa.in_data = 16'h0666;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rr_stall_ready", 32'(ifa.in_ready), 32'h0);
      tick();
      chk("rr_stall_ptr", 32'(ifa.rr_ptr), 32'd5);
      chk("rr_stall_data5", 32'(cha(5)), 32'h0555);
    end
    ifa.out_ready = '1;
    #1;
    chk("rr_unstall_ready", 32'(ifa.in_ready), 32'h1);
    tick();
    chk("rr_unstall_ptr", 32'(ifa.rr_ptr), 32'd6);
    chk("rr_unstall_data5", 32'(cha(5)), 32'h0666);
    ifa.in_valid = 1'b0; ifa.mode = 1'b0;
    tick();

    // Out-of-range on the 10-way instance
    ifb.sel = 4'd12; ifb.mode = 1'b0; ifb.in_valid = 1'b1; ifb.in_data = 16'hDEAD;
    for (int k = 0; k < 300; k++) begin
      #1;
      chk("oor_ready", 32'(ifb.in_ready), 32'h1);
      tick();
      chk("oor_err", 32'(ifb.err), 32'h1);
      chk("oor_no_valid", 32'(ifb.out_valid), 32'h0);
      chk("oor_drop", 32'(ifb.drop_cnt), 32'((k + 1 > 255) ? 255 : k + 1));
    end
    ifb.in_valid = 1'b0;
    tick();
    chk("oor_err_clear", 32'(ifb.err), 32'h0);
    chk("oor_drop_sat", 32'(ifb.drop_cnt), 32'd255);

    // Asynchronous reset with words held in channels 2 and 7
    ifa.out_ready = '0; ifa.mode = 1'b0; ifa.in_valid = 1'b1;
    ifa.sel = 4'd2; ifa.in_data = 16'h2222;
    tick();
    ifa.sel = 4'd7; ifa.in_data = 16'h7777;
    tick();
    ifa.in_valid = 1'b0;
    chk("ar_held", 32'(ifa.out_valid), 32'h0084);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_now", 32'(ifa.out_valid), 32'h0);
    chk("ar_data_now", 32'(ifa.out_data == '0), 32'h1);
    chk("ar_rr_now", 32'(ifa.rr_ptr), 32'h0);
    chk("ar_drop_b_now", 32'(ifb.drop_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ifa.out_ready = '1; ifa.sel = 4'd9; ifa.in_data = 16'h9999; ifa.in_valid = 1'b1;
    tick();
    chk("ar_resume_valid", 32'(ifa.out_valid), 32'h0200);
    chk("ar_resume_data", 32'(cha(9)), 32'h9999);
    ifa.in_valid = 1'b0;
    tick();
    chk("ar_resume_drained", 32'(ifa.out_valid), 32'h0);

    // Randomized traffic against the model
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++) begin
        mv[u][i] = 1'b0;
        md[u][i] = '0;
      end
      mp[u] = 0; mdrop[u] = 0; merr[u] = 1'b0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int u = 0; u < 2; u++) begin
        sv[u] = ($urandom_range(0, 3) != 0);
        sm[u] = $urandom_range(0, 1) == 1;
        ss[u] = 4'($urandom_range(0, 15));
        sd[u] = 16'($urandom);
        sr[u] = 16'($urandom) | 16'($urandom);
      end
      ifa.in_valid = sv[0]; ifa.mode = sm[0]; ifa.sel = ss[0];
      ifa.in_data = sd[0]; ifa.out_ready = sr[0];
      ifb.in_valid = sv[1]; ifb.mode = sm[1]; ifb.sel = ss[1];
      ifb.in_data = sd[1]; ifb.out_ready = sr[1][9:0];
      #1;
      for (int u = 0; u < 2; u++) begin
        int n;
        int d;
        bit er;
        bit x;
        n  = (u == 0) ? 16 : 10;
        d  = sm[u] ? mp[u] : int'(ss[u]);
        er = (d >= n) ? 1'b1 : (!mv[u][d] || sr[u][d]);
        chk(u == 0 ? "rnd_a_ready" : "rnd_b_ready",
            32'(u == 0 ? ifa.in_ready : ifb.in_ready), 32'(er));
        x = sv[u] && er;
        for (int i = 0; i < n; i++) begin
          if (sr[u][i]) mv[u][i] = 1'b0;
        end
        if (x && d < n) begin
          mv[u][d] = 1'b1;
          md[u][d] = sd[u];
        end
        merr[u] = x && (d >= n);
        if (merr[u] && mdrop[u] < 255) mdrop[u]++;
        if (x && sm[u]) mp[u] = (mp[u] + 1) % n;
      end
      tick();
      for (int u = 0; u < 2; u++) begin
        logic [15:0] ev;
        int n;
        n  = (u == 0) ? 16 : 10;
        ev = '0;
        for (int i = 0; i < n; i++) ev[i] = mv[u][i];
        if (u == 0) begin
          chk("rnd_a_valid", 32'(ifa.out_valid), 32'(ev));
          chk("rnd_a_rr", 32'(ifa.rr_ptr), 32'(mp[0]));
          chk("rnd_a_err", 32'(ifa.err), 32'(merr[0]));
          chk("rnd_a_drop", 32'(ifa.drop_cnt), 32'(mdrop[0]));
          for (int i = 0; i < 16; i++) begin
            if (mv[0][i]) chk("rnd_a_data", 32'(cha(i)), 32'(md[0][i]));
          end
        end else begin
          chk("rnd_b_valid", 32'(ifb.out_valid), 32'(ev));
          chk("rnd_b_rr", 32'(ifb.rr_ptr), 32'(mp[1]));
          chk("rnd_b_err", 32'(ifb.err), 32'(merr[1]));
          chk("rnd_b_drop", 32'(ifb.drop_cnt), 32'(mdrop[1]));
          for (int i = 0; i < 10; i++) begin
            if (mv[1][i]) chk("rnd_b_data", 32'(chb(i)), 32'(md[1][i]));
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_stream_1_n.md
Name: demux_stream_1_n

Overview:
- Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking on the input and on every output channel.
- Successor to the fixed 16-bit, 16-way combinational demux. Adds:
  - configurable data width and channel count;
  - a one-entry holding register per channel;
  - an addressed mode and an auto-incrementing round-robin mode;
  - out-of-range select detection.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
WIDTH, 16, data width in bits of input and of each output channel
N_OUT, 16, number of output channels (2..256; need not be a power of two)
SEL_W, $clog2(N_OUT), select/pointer width; derived, never overridden

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block accepts the word this cycle
in_data  input  WIDTH  input word
sel  input  SEL_W  destination channel in addressed mode
mode  input  1  0 = addressed (use sel), 1 = round-robin (use rr_ptr)
out_valid  output  N_OUT  bit i: channel i holds a word
out_ready  input  N_OUT  bit i: consumer i takes the word this cycle
out_data  output  N_OUT*WIDTH  flattened; channel i = bits [i*WIDTH +: WIDTH]
rr_ptr  output  SEL_W  current round-robin destination
err  output  1  one-cycle pulse: word accepted with out-of-range destination
drop_cnt  output  8  saturating count of out-of-range drops

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state (asynchronous assertion, synchronous release):
  - all out_valid = 0, all channel data = 0;
  - rr_ptr = 0, err = 0, drop_cnt = 0.
- Reset mid-transfer discards all held words.
- Destination d = (mode ? rr_ptr : sel). d is combinational, so a mode or sel change takes effect in the same cycle.
- in_ready is combinational:
  - = 1 when d >= N_OUT;
  - otherwise = !out_valid[d] || out_ready[d].
  - It never depends on in_valid.
- Transfer occurs when in_valid && in_ready.
- In-range transfer:
  - channel d register loads in_data and out_valid[d] is set;
  - out_valid[d] rises on the next edge, giving 1-cycle latency.
- Drain: when out_valid[i] && out_ready[i], channel i clears, unless it is reloaded in the same cycle.
- Simultaneous drain and load on the same channel: the new word replaces the old one and out_valid stays 1. This gives full throughput of one word per cycle per channel.
- Stability: while out_valid[i] && !out_ready[i], out_data for channel i and out_valid[i] hold unchanged.
- Untargeted channels are never modified by a transfer.
- Out-of-range transfer (d >= N_OUT, only possible when N_OUT is not a power of two):
  - the word is consumed and discarded;
  - err = 1 for the following cycle only;
  - drop_cnt increments and saturates at 255.
- rr_ptr:
  - advances only on an accepted transfer while mode = 1;
  - wraps from N_OUT-1 to 0;
  - holds in mode 0 and holds while stalled.
- A stalled round-robin target blocks the input. The block never skips a channel.
- Multiple channels may drain in the same cycle, independently of input activity.

Test Plan:
1. Reset and addressed sweep: N_OUT=16, WIDTH=16. Assert rst_n=0, then sweep sel 0..15 with all out_ready=1 and in_data=16'hA500+sel.
   - During reset, all outputs are 0.
   - After reset, out_valid[sel] pulses one cycle after each transfer, with the matching data; no other channel changes.
2. Backpressure: out_ready[3]=0, send 16'h1234 then 16'h5678 to channel 3.
   - The first word is held: out_valid[3]=1, data 1234.
   - in_ready=0 for the second word, which stays pending.
   - Raise out_ready[3]: in the same cycle in_ready=1; the next cycle's data is 5678 and out_valid[3] stays 1.
3. Round-robin: mode=1, in_valid=1 for 20 cycles, all ready.
   - Words land on channels 0..15 then 0..3.
   - rr_ptr reads 4 at the end.
   - Stalling out_ready[5] freezes rr_ptr at 5.
4. Out-of-range: N_OUT=10, sel=12, 300 transfers.
   - in_ready=1 throughout and no out_valid rises.
   - err pulses each cycle after a transfer.
   - drop_cnt saturates at 255.
5. Async reset mid-operation: with channels 2 and 7 holding words, drop rst_n between clock edges.
   - out_valid goes to 0 immediately, without waiting for a clock edge.
   - rr_ptr and drop_cnt are 0.
   - Normal operation resumes on the first edge after release.
